// File: rtl/fifo_rd_adapter_pkg.sv
// Shared types and constants for the fifo read adapter.
// Packet framing (pkt_len/m_last) is enabled by defining FIFO_RD_ADAPTER_LAST_EN.
package fifo_rd_adapter_pkg;

    localparam int unsigned ADPT_BUF_DEPTH = 2;

    // Encoding equals the number of buffered words, so occupancy arithmetic can use it directly.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } fifo_rd_occ_t;

    function automatic logic [1:0] occ_count(input fifo_rd_occ_t occ);
        return logic'(occ[1]) ? 2'd2 : {1'b0, occ[0]};
    endfunction

endpackage

// File: rtl/fifo_rd_adapter_if.sv
// Fifo read port plus valid/ready stream bundle; master = adapter side, slave = fifo/sink side.
// pkt_len and m_last exist only when FIFO_RD_ADAPTER_LAST_EN is defined.
interface fifo_rd_adapter_if #(
    parameter int unsigned WORD_WDT    = 64,
    parameter int unsigned PKT_LEN_WDT = 16
);
    logic                fifo_empty;
    logic                fifo_rd;
    logic [WORD_WDT-1:0] fifo_word;
    logic                m_valid;
    logic                m_ready;
    logic [WORD_WDT-1:0] m_data;
`ifdef FIFO_RD_ADAPTER_LAST_EN
    logic [PKT_LEN_WDT-1:0] pkt_len;
    logic                   m_last;
`endif

    if (WORD_WDT < 1 || PKT_LEN_WDT < 1) begin : g_bad_width
        $error("fifo_rd_adapter_if: widths must be at least 1");
    end

    modport master (
        input  fifo_empty, fifo_word, m_ready,
        output fifo_rd, m_valid, m_data
`ifdef FIFO_RD_ADAPTER_LAST_EN
        , input pkt_len, output m_last
`endif
    );

    modport slave (
        output fifo_empty, fifo_word, m_ready,
        input  fifo_rd, m_valid, m_data
`ifdef FIFO_RD_ADAPTER_LAST_EN
        , output pkt_len, input m_last
`endif
    );

endinterface

// File: rtl/fifo_rd_pkt_cnt.sv
// Beat counter for packet framing: flags the last beat of each pkt_len-beat packet.
// Instantiated only when FIFO_RD_ADAPTER_LAST_EN is defined.
module fifo_rd_pkt_cnt #(
    parameter int unsigned PKT_LEN_WDT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pop,
    input  logic [PKT_LEN_WDT-1:0] pkt_len,
    output logic                   last
);
    logic [PKT_LEN_WDT-1:0] cnt;

    // A length of 0 or 1 makes every beat a single-beat packet.
    assign last = (pkt_len <= PKT_LEN_WDT'(1)) || (cnt == pkt_len - PKT_LEN_WDT'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (pop) begin
            cnt <= last ? '0 : cnt + PKT_LEN_WDT'(1);
        end
    end

endmodule

// File: rtl/fifo_rd_adapter.sv
// Turns a 1-cycle-latency fifo read port into a valid/ready stream via a 2-entry buffer.
// Define FIFO_RD_ADAPTER_LAST_EN to add pkt_len/m_last packet framing.
module fifo_rd_adapter
    import fifo_rd_adapter_pkg::*;
#(
    parameter int unsigned WORD_WDT    = 64,
    parameter int unsigned PKT_LEN_WDT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    fifo_rd_adapter_if.master   bus
);
    fifo_rd_occ_t        occ, occ_nxt;
    logic                rd_pend;
    logic [WORD_WDT-1:0] head, tail;
    logic                valid, pop, push;
    logic [2:0]          fill;
    logic                head_ld, head_from_tail, tail_ld;

    if (WORD_WDT < 1 || PKT_LEN_WDT < 1) begin : g_bad_width
        $error("fifo_rd_adapter: widths must be at least 1");
    end

    assign valid = rst_n & (occ != EMPTY);
    assign pop   = valid & bus.m_ready;
    assign push  = rd_pend;

    // Words held or in flight after this edge; a new read is allowed only if it still fits.
    assign fill = {1'b0, occ_count(occ)} + {2'b0, rd_pend} - {2'b0, pop};

    assign bus.fifo_rd = rst_n & ~bus.fifo_empty & (fill < 3'(ADPT_BUF_DEPTH));
    assign bus.m_valid = valid;
    assign bus.m_data  = head;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ     <= EMPTY;
            rd_pend <= 1'b0;
        end else begin
            occ     <= occ_nxt;
            rd_pend <= bus.fifo_rd;
        end
    end

    always_comb begin
        occ_nxt        = occ;
        head_ld        = 1'b0;
        head_from_tail = 1'b0;
        tail_ld        = 1'b0;
        case (occ)
            EMPTY: begin
                if (push) begin
                    occ_nxt = ONE;
                    head_ld = 1'b1;
                end
            end
            ONE: begin
                case ({push, pop})
                    2'b10:   begin occ_nxt = TWO; tail_ld = 1'b1; end
                    2'b01:   occ_nxt = EMPTY;
                    2'b11:   head_ld = 1'b1;
                    default: ;
                endcase
            end
            TWO: begin
                // The read throttle keeps a push from arriving into TWO without a pop.
                if (pop) begin
                    head_ld        = 1'b1;
                    head_from_tail = 1'b1;
                    if (push) tail_ld = 1'b1;
                    else      occ_nxt = ONE;
                end
            end
            default: occ_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (head_ld) head <= head_from_tail ? tail : bus.fifo_word;
            if (tail_ld) tail <= bus.fifo_word;
        end
    end

`ifdef FIFO_RD_ADAPTER_LAST_EN
    logic last_beat;

    fifo_rd_pkt_cnt #(.PKT_LEN_WDT(PKT_LEN_WDT)) u_pkt_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .pop     (pop),
        .pkt_len (bus.pkt_len),
        .last    (last_beat)
    );

    assign bus.m_last = valid & last_beat;
`endif

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Scoreboard bench for fifo_rd_adapter with a behavioural depth-8 registered-output fifo.
// Framing checks run only when FIFO_RD_ADAPTER_LAST_EN is defined.
module tb_fifo_rd_adapter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_rd_adapter_if #(.WORD_WDT(64), .PKT_LEN_WDT(16)) bus ();

    fifo_rd_adapter #(.WORD_WDT(64), .PKT_LEN_WDT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural fifo: read data is registered, one cycle after fifo_rd.
    logic        wr_en;
    logic [63:0] wr_data;
    logic [63:0] mem [8];
    int          wp, rp, fcnt;

    assign bus.fifo_empty = (fcnt == 0);

    always @(posedge clk) begin
        if (!rst_n) begin
            wp            <= 0;
            rp            <= 0;
            fcnt          <= 0;
            bus.fifo_word <= '0;
        end else begin
            if (wr_en) begin
                mem[wp] <= wr_data;
                wp      <= (wp + 1) % 8;
            end
            if (bus.fifo_rd) begin
                bus.fifo_word <= mem[rp];
                rp            <= (rp + 1) % 8;
            end
            fcnt <= fcnt + (wr_en ? 1 : 0) - (bus.fifo_rd ? 1 : 0);
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard and continuous protocol monitor, sampled on the falling edge.
    logic [63:0] sb [$];
    logic        last_log [$];
    int          pops = 0;
    int          outst = 0;
    logic        prev_hold = 1'b0;
    logic [63:0] prev_data;

    always @(negedge clk) begin
        check("rd_when_empty", 64'(bus.fifo_rd & bus.fifo_empty), 64'(0));
        check("occ_bound", 64'(outst <= 2), 64'(1));
        if (prev_hold) begin
            check("hold_valid", 64'(bus.m_valid), 64'(1));
            check("hold_data", bus.m_data, prev_data);
        end
        prev_hold = bus.m_valid & ~bus.m_ready;
        prev_data = bus.m_data;
        if (bus.m_valid && bus.m_ready) begin
            if (sb.size() == 0) begin
                check("stray_word", bus.m_data, 64'hdead_dead_dead_dead);
            end else begin
                check("data", bus.m_data, sb.pop_front());
            end
`ifdef FIFO_RD_ADAPTER_LAST_EN
            last_log.push_back(bus.m_last);
`endif
            pops++;
        end
        outst = outst + (bus.fifo_rd ? 1 : 0) - ((bus.m_valid && bus.m_ready) ? 1 : 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [63:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        sb.push_back(d);
    endtask

    task automatic stream(input int n, input logic [63:0] base, input int ready_pct, input int gap_pct);
        int sent   = 0;
        int target = pops + n;
        int budget = 100 + n * 20;
        int c      = 0;
        while (pops < target && c < budget) begin
            tick();
            wr_en = 1'b0;
            if (sent < n && fcnt < 8 && $urandom_range(99) >= 32'(gap_pct)) begin
                put(base + 64'(sent));
                sent++;
            end
            bus.m_ready = ($urandom_range(99) < 32'(ready_pct));
            c++;
        end
        check("stream_done", 64'(pops), 64'(target));
        tick();
        wr_en       = 1'b0;
        bus.m_ready = 1'b1;
    endtask

    initial begin
        int          t_rd, t_v, t_first, t_last, np, nrd;
        logic        seen;
        logic [8:0]  mask;

        rst_n       = 1'b0;
        wr_en       = 1'b0;
        wr_data     = '0;
        bus.m_ready = 1'b0;
`ifdef FIFO_RD_ADAPTER_LAST_EN
        bus.pkt_len = 16'd3;
`endif

        // Reset held for 3 cycles, then 10 idle cycles with the fifo empty.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_fifo_rd", 64'(bus.fifo_rd), 64'(0));
            check("rst_m_valid", 64'(bus.m_valid), 64'(0));
        end
        tick();
        rst_n       = 1'b1;
        bus.m_ready = 1'b1;
        @(negedge clk);
        check("rst_m_data", bus.m_data, 64'(0));
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            check("idle_fifo_rd", 64'(bus.fifo_rd), 64'(0));
            check("idle_m_valid", 64'(bus.m_valid), 64'(0));
        end
        tick();

`ifdef FIFO_RD_ADAPTER_LAST_EN
        last_log.delete();
        stream(9, 64'h100, 100, 0);
        mask = '0;
        for (int i = 0; i < 9; i++) if (i < last_log.size()) mask[i] = last_log[i];
        check("last_len3", 64'(mask), 64'(9'b100_100_100));

        bus.pkt_len = 16'd1;
        last_log.delete();
        stream(4, 64'h200, 100, 0);
        mask = '0;
        for (int i = 0; i < 4; i++) if (i < last_log.size()) mask[i] = last_log[i];
        check("last_len1", 64'(mask), 64'(9'b000_001_111));

        bus.pkt_len = 16'd0;
        last_log.delete();
        stream(2, 64'h300, 100, 0);
        mask = '0;
        for (int i = 0; i < 2; i++) if (i < last_log.size()) mask[i] = last_log[i];
        check("last_len0", 64'(mask), 64'(9'b000_000_011));
        bus.pkt_len = 16'd1;
`endif

        // Streaming: 8 words, latency and throughput.
        t_rd = -1; t_v = -1; t_first = -1; t_last = -1; np = 0;
        bus.m_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (c < 8) put(64'(c + 1));
            else       wr_en = 1'b0;
            @(negedge clk);
            if (bus.fifo_rd && t_rd < 0) t_rd = c;
            if (bus.m_valid && t_v < 0)  t_v = c;
            if (bus.m_valid && bus.m_ready) begin
                if (t_first < 0) t_first = c;
                t_last = c;
                np++;
            end
            tick();
        end
        check("stream_latency", 64'(t_v - t_rd), 64'(2));
        check("stream_count", 64'(np), 64'(8));
        check("stream_b2b", 64'(t_last - t_first), 64'(7));

        // Backpressure: stall while words are available.
        nrd = 0;
        bus.m_ready = 1'b0;
        for (int c = 0; c < 9; c++) begin
            if (c < 4) put(64'(c + 1));
            else       wr_en = 1'b0;
            @(negedge clk);
            if (bus.fifo_rd) nrd++;
            if (c >= 4) begin
                check("bp_valid", 64'(bus.m_valid), 64'(1));
                check("bp_hold", bus.m_data, 64'(1));
            end
            tick();
        end
        check("bp_reads", 64'(nrd), 64'(2));
        bus.m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_rel_valid", 64'(bus.m_valid), 64'(1));
            check("bp_rel_data", bus.m_data, 64'(k + 1));
            tick();
        end
        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        check("bp_drain", 64'(sb.size()), 64'(0));

        // Random sink stalls and writer gaps.
        stream(1000, 64'h1000, 60, 30);

        // Mid-stream reset with the buffer and in-flight slot both occupied.
        seen = 1'b0;
        bus.m_ready = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (c < 3) put(64'h500 + 64'(c));
            else       wr_en = 1'b0;
            @(negedge clk);
            if (bus.m_valid) seen = 1'b1;
            else             tick();
        end
        check("mrst_setup", 64'(seen), 64'(1));
        #1;
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        sb.delete();
        outst     = 0;
        prev_hold = 1'b0;
        tick();
        rst_n       = 1'b1;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("mrst_m_valid", 64'(bus.m_valid), 64'(0));
            check("mrst_fifo_rd", 64'(bus.fifo_rd), 64'(0));
            if (i == 0) check("mrst_m_data", bus.m_data, 64'(0));
            tick();
        end
        stream(5, 64'h600, 100, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
